mips32_bench_ctrl: RTL
======================

Name: mips32_bench_ctrl

Overview:
- Synthesizable, parametrised program-load and result-dump controller for the mips32 core; replaces fixed-time, hierarchical-poke bring-up.
- Streams a program into instruction memory while holding the core, then runs the core until halt or cycle budget.
- Scans a window of register-file entries and data-memory words out over a valid/ready dump stream.
- Sits between the host/bench interface and the core's imem write port, hold input, and debug read ports.

Parameters:
- XLEN, 32, data/instruction word width
- IMEM_AW, 10, instruction memory address width (depth 2**IMEM_AW)
- DMEM_AW, 10, data memory address width
- LOAD_BASE, 1, first imem address written by a load
- NREG_DUMP, 4, registers dumped, starting at R1 (R1..R NREG_DUMP); range 1..31
- DMEM_BASE, 1, first dmem word dumped
- NMEM_DUMP, 3, dmem words dumped; 0 skips memory dump
- MAX_CYCLES, 10, run budget in clk_x cycles; must be >= 1

Ports:
- clk_x in 1: sole clock, all state on rising edge
- rst in 1: synchronous active-high reset
- start in 1: pulse in IDLE begins a session
- ld_valid in 1: program word valid
- ld_ready out 1: controller accepts program word
- ld_data in XLEN: program word
- ld_last in 1: marks final program word
- imem_we out 1: imem write strobe
- imem_addr out IMEM_AW: imem write address
- imem_wdata out XLEN: imem write data
- cpu_hold out 1: 1 freezes core (no PC/reg/mem update)
- cpu_halt in 1: core reports halt instruction retired
- rf_raddr out 5: debug register read address (combinational read)
- rf_rdata in XLEN: debug register data
- dm_raddr out DMEM_AW: debug dmem read address (combinational read)
- dm_rdata in XLEN: debug dmem data
- dump_valid out 1: dump word valid
- dump_ready in 1: consumer accepts dump word
- dump_data out XLEN: dump payload
- dump_is_mem out 1: 0 = register word, 1 = dmem word
- dump_idx out 10: register number or dmem address of the payload
- cycle_cnt out 32: run cycles elapsed in the last/current run
- timeout out 1: run ended by budget, not halt
- load_err out 1: program overflowed imem
- done out 1: session complete

Behaviour:
- Reset values (synchronous, overrides all): state IDLE; cpu_hold=1; ld_ready=0; imem_we=0; imem_addr=0; imem_wdata=0; rf_raddr=0; dm_raddr=0; dump_valid=0; dump_data=0; dump_is_mem=0; dump_idx=0; cycle_cnt=0; timeout=0; load_err=0; done=0.
- rst mid-session aborts immediately.
  - Partial imem writes are not undone.
  - cpu_hold returns to 1 on the cycle after the reset edge.
- FSM states: IDLE, LOAD, RUN, DUMP_REG, DUMP_MEM, DONE.
- IDLE:
  - cpu_hold=1.
  - start=1 → LOAD; clears done, timeout, load_err, cycle_cnt; write pointer := LOAD_BASE.
  - start is ignored in every state except IDLE and DONE.
- LOAD:
  - ld_ready=1.
  - Each ld_valid&ld_ready cycle registers imem_we=1, imem_addr=ptr, imem_wdata=ld_data, visible on the next cycle; ptr increments.
  - imem_we is 0 on cycles without a handshake.
  - Handshake with ld_last=1 → RUN next cycle.
  - Word accepted at ptr = 2**IMEM_AW-1 without ld_last: load_err=1, state → DONE, no run, no wrap.
- RUN:
  - cpu_hold=0.
  - cycle_cnt increments every RUN cycle, saturating at 2**32-1.
  - Exit to DUMP_REG on the edge where cpu_halt=1 (timeout=0), or where cycle_cnt reaches MAX_CYCLES (timeout=1).
  - If both occur on the same cycle, halt wins (timeout=0).
  - cpu_hold=1 from the first cycle after RUN.
- DUMP_REG:
  - rf_raddr walks 1..NREG_DUMP.
  - Presents dump_valid=1, dump_data=rf_rdata, dump_is_mem=0, dump_idx=reg.
  - Payload stays stable while dump_valid & !dump_ready.
  - Advances only on handshake; back-to-back handshakes yield one word per cycle.
  - After the last register: → DUMP_MEM, or → DONE if NMEM_DUMP=0.
- DUMP_MEM:
  - Same rules as DUMP_REG, addresses DMEM_BASE..DMEM_BASE+NMEM_DUMP-1, dump_is_mem=1.
  - Addresses wrap modulo 2**DMEM_AW.
- DONE:
  - done=1; cpu_hold=1; status outputs held.
  - start=1 begins a new session, same as from IDLE.
- dump_valid never drops without a handshake except on rst.

Test Plan:
- Load 5 words (c0200001, c0400002, 00611000, 48830002, c4800003, last on word 5), ld_valid held high → imem_we pulses at addresses 1..5 on consecutive cycles with matching data; cpu_hold=1 throughout LOAD.
- Run with cpu_halt asserted on run cycle 6, MAX_CYCLES=10 → cycle_cnt=6, timeout=0, cpu_hold back to 1 next cycle; no halt within 10 cycles → cycle_cnt=10, timeout=1.
- Dump with dump_ready=1 → 4 register words (idx 1..4, dump_is_mem=0), then 3 dmem words (idx 1..3, dump_is_mem=1) on 7 consecutive cycles, then done=1.
- Dump with dump_ready toggling 1,0,0,1 → payload and idx stable across stall cycles; no word lost or duplicated.
- Load with IMEM_AW=3, 8 words and no ld_last → load_err=1, done=1, cpu_hold never deasserted, cycle_cnt=0.
- Assert rst in RUN at cycle 3, then start again → all outputs at reset values; second session completes normally with cycle_cnt restarting at 0.

Source files
------------

// File: rtl/mips32_bench_ctrl.sv
// Program-load / run / result-dump controller wrapped around the mips32 core.
// Latency: imem write lands 1 cycle after a load handshake; dump words appear 1 cycle after the slot frees.
// Backpressure: ld_ready is high for the whole load phase; dump_valid/dump_data are held while !dump_ready.
//
// Ports:
//   clk_x, rst                  clock and synchronous active-high reset
//   start                       begins a session from IDLE or DONE
//   ld_valid/ld_ready/ld_data/ld_last   program word stream into imem
//   imem_we/imem_addr/imem_wdata        registered imem write port
//   cpu_hold, cpu_halt          core freeze control and halt report
//   rf_raddr/rf_rdata, dm_raddr/dm_rdata  combinational debug read ports of the core
//   dump_valid/dump_ready/dump_data/dump_is_mem/dump_idx   result dump stream
//   cycle_cnt, timeout, load_err, done  session status
module mips32_bench_ctrl #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned IMEM_AW    = 10,
    parameter int unsigned DMEM_AW    = 10,
    parameter int unsigned LOAD_BASE  = 1,
    parameter int unsigned NREG_DUMP  = 4,
    parameter int unsigned DMEM_BASE  = 1,
    parameter int unsigned NMEM_DUMP  = 3,
    parameter int unsigned MAX_CYCLES = 10
) (
    input  logic               clk_x,
    input  logic               rst,
    input  logic               start,
    input  logic               ld_valid,
    output logic               ld_ready,
    input  logic [XLEN-1:0]    ld_data,
    input  logic               ld_last,
    output logic               imem_we,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic [XLEN-1:0]    imem_wdata,
    output logic               cpu_hold,
    input  logic               cpu_halt,
    output logic [4:0]         rf_raddr,
    input  logic [XLEN-1:0]    rf_rdata,
    output logic [DMEM_AW-1:0] dm_raddr,
    input  logic [XLEN-1:0]    dm_rdata,
    output logic               dump_valid,
    input  logic               dump_ready,
    output logic [XLEN-1:0]    dump_data,
    output logic               dump_is_mem,
    output logic [9:0]         dump_idx,
    output logic [31:0]        cycle_cnt,
    output logic               timeout,
    output logic               load_err,
    output logic               done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_DUMP_REG,
        S_DUMP_MEM,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic [IMEM_AW-1:0] ptr_q;
    logic               imem_we_q;
    logic [IMEM_AW-1:0] imem_addr_q;
    logic [XLEN-1:0]    imem_wdata_q;
    logic [31:0]        cycle_cnt_q;
    logic               timeout_q;
    logic               load_err_q;
    logic [4:0]         rf_raddr_q;
    logic [DMEM_AW-1:0] dm_raddr_q;
    logic [31:0]        mem_cnt_q;
    logic               last_issued_q;
    logic               dump_valid_q;
    logic [XLEN-1:0]    dump_data_q;
    logic               dump_is_mem_q;
    logic [9:0]         dump_idx_q;

    logic        ptr_at_end;
    logic [31:0] cnt_inc;
    logic        budget_hit;
    logic        dump_load;
    logic        last_reg;
    logic        last_mem;

    assign ptr_at_end = (ptr_q == {IMEM_AW{1'b1}});
    // Saturating run counter.
    assign cnt_inc    = (cycle_cnt_q == 32'hFFFF_FFFF) ? cycle_cnt_q : cycle_cnt_q + 32'd1;
    assign budget_hit = (cnt_inc >= 32'(MAX_CYCLES));
    // Output slot is free when empty or being drained this cycle; the debug
    // reads are combinational, so a new word can be captured on the same edge.
    assign dump_load  = !dump_valid_q || dump_ready;
    assign last_reg   = (rf_raddr_q == 5'(NREG_DUMP));
    assign last_mem   = (mem_cnt_q == 32'(NMEM_DUMP) - 32'd1);

    // State register
    always_ff @(posedge clk_x) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic. The dump states name the source of the next word to
    // fetch; the word on the output may still belong to the previous source.
    // last_issued_q marks that nothing remains to fetch, so the session only
    // completes once that final word has been handshaken.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) state_d = S_LOAD;
            end
            S_LOAD: begin
                if (ld_valid) begin
                    if (ld_last)         state_d = S_RUN;
                    else if (ptr_at_end) state_d = S_DONE;
                end
            end
            S_RUN: begin
                if (cpu_halt || budget_hit) state_d = S_DUMP_REG;
            end
            S_DUMP_REG: begin
                if (dump_load) begin
                    if (last_issued_q)                   state_d = S_DONE;
                    else if (last_reg && NMEM_DUMP != 0) state_d = S_DUMP_MEM;
                end
            end
            S_DUMP_MEM: begin
                if (dump_load && last_issued_q) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode
    always_comb begin
        cpu_hold = 1'b1;
        ld_ready = 1'b0;
        done     = 1'b0;
        case (state_q)
            S_LOAD:  ld_ready = 1'b1;
            S_RUN:   cpu_hold = 1'b0;
            S_DONE:  done     = 1'b1;
            default: ;
        endcase
    end

    // Datapath
    always_ff @(posedge clk_x) begin
        if (rst) begin
            ptr_q         <= '0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            cycle_cnt_q   <= '0;
            timeout_q     <= 1'b0;
            load_err_q    <= 1'b0;
            rf_raddr_q    <= '0;
            dm_raddr_q    <= '0;
            mem_cnt_q     <= '0;
            last_issued_q <= 1'b0;
            dump_valid_q  <= 1'b0;
            dump_data_q   <= '0;
            dump_is_mem_q <= 1'b0;
            dump_idx_q    <= '0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ptr_q       <= IMEM_AW'(LOAD_BASE);
                        cycle_cnt_q <= '0;
                        timeout_q   <= 1'b0;
                        load_err_q  <= 1'b0;
                    end
                end
                S_LOAD: begin
                    if (ld_valid) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= ptr_q;
                        imem_wdata_q <= ld_data;
                        // The top word is still written; the load just stops there.
                        if (!ld_last && ptr_at_end) load_err_q <= 1'b1;
                        if (!ptr_at_end)            ptr_q <= ptr_q + IMEM_AW'(1);
                    end
                end
                S_RUN: begin
                    cycle_cnt_q <= cnt_inc;
                    if (cpu_halt || budget_hit) begin
                        timeout_q     <= !cpu_halt;   // halt wins a tie with the budget
                        rf_raddr_q    <= 5'd1;
                        dm_raddr_q    <= DMEM_AW'(DMEM_BASE);
                        mem_cnt_q     <= '0;
                        last_issued_q <= 1'b0;
                    end
                end
                S_DUMP_REG: begin
                    if (dump_load) begin
                        if (last_issued_q) begin
                            dump_valid_q <= 1'b0;
                        end else begin
                            dump_valid_q  <= 1'b1;
                            dump_data_q   <= rf_rdata;
                            dump_is_mem_q <= 1'b0;
                            dump_idx_q    <= 10'(rf_raddr_q);
                            if (last_reg) begin
                                if (NMEM_DUMP == 0) last_issued_q <= 1'b1;
                            end else begin
                                rf_raddr_q <= rf_raddr_q + 5'd1;
                            end
                        end
                    end
                end
                S_DUMP_MEM: begin
                    if (dump_load) begin
                        if (last_issued_q) begin
                            dump_valid_q <= 1'b0;
                        end else begin
                            dump_valid_q  <= 1'b1;
                            dump_data_q   <= dm_rdata;
                            dump_is_mem_q <= 1'b1;
                            dump_idx_q    <= 10'(dm_raddr_q);
                            if (last_mem) begin
                                last_issued_q <= 1'b1;
                            end else begin
                                dm_raddr_q <= dm_raddr_q + DMEM_AW'(1);
                                mem_cnt_q  <= mem_cnt_q + 32'd1;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign rf_raddr    = rf_raddr_q;
    assign dm_raddr    = dm_raddr_q;
    assign dump_valid  = dump_valid_q;
    assign dump_data   = dump_data_q;
    assign dump_is_mem = dump_is_mem_q;
    assign dump_idx    = dump_idx_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign timeout     = timeout_q;
    assign load_err    = load_err_q;

endmodule
